// File: rtl/sdu_ping_ctrl_if.sv
// Control/status bundle between the PC-side sequencing logic (master) and the
// ping controller (slave) that gates the SDUltrasound TX replay stage.
interface sdu_ping_ctrl_if #(
  parameter int LEN_W = 16,
  parameter int GAP_W = 32,
  parameter int IDX_W = 16
);
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] cfg_tx_len;
  logic [LEN_W-1:0] cfg_rx_len;
  logic [GAP_W-1:0] cfg_gap;
  logic [IDX_W-1:0] cfg_num_pings;
  logic             tx_en;
  logic             rx_en;
  logic             busy;
  logic             ping_start_strobe;
  logic             seq_done_strobe;
  logic [IDX_W-1:0] ping_idx;

  modport master (
    output start, abort, cfg_tx_len, cfg_rx_len, cfg_gap, cfg_num_pings,
    input  tx_en, rx_en, busy, ping_start_strobe, seq_done_strobe, ping_idx
  );

  modport slave (
    input  start, abort, cfg_tx_len, cfg_rx_len, cfg_gap, cfg_num_pings,
    output tx_en, rx_en, busy, ping_start_strobe, seq_done_strobe, ping_idx
  );
endinterface

// File: rtl/sdu_ping_ctrl.sv
// Ping sequencer: TX burst, RX listen window, inter-ping gap, repeated N times.
// Define SDU_PING_EXT_TRIG_EN to hold every TX phase until an ext_trig rising edge.
module sdu_ping_ctrl #(
  parameter int LEN_W = 16,
  parameter int GAP_W = 32,
  parameter int IDX_W = 16
) (
  input  logic clk,
  input  logic reset,
`ifdef SDU_PING_EXT_TRIG_EN
  input  logic ext_trig,
`endif
  sdu_ping_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_RX, S_GAP, S_DONE, S_ARM} state_t;

  state_t           state, state_n, ping_end;
  logic [LEN_W-1:0] tx_len_q, rx_len_q, len_cnt, len_cnt_n;
  logic [GAP_W-1:0] gap_q, gap_cnt, gap_cnt_n, gap_load;
  logic [IDX_W-1:0] num_q, idx, idx_n, idx_inc;
  logic             latch, last_ping;

`ifdef SDU_PING_EXT_TRIG_EN
  // [0],[1] synchronise; [2] is the previous synchronised value for edge detect
  logic [2:0] trig_sync;
  logic       trig_edge;

  always_ff @(posedge clk) begin
    if (reset) trig_sync <= '0;
    else       trig_sync <= {trig_sync[1:0], ext_trig};
  end

  assign trig_edge = trig_sync[1] & ~trig_sync[2];
  localparam state_t PING_ENTRY = S_ARM;
`else
  localparam state_t PING_ENTRY = S_TX;
`endif

  assign idx_inc   = idx + IDX_W'(1);
  assign last_ping = (num_q != '0) && (idx_inc == num_q);
  assign ping_end  = last_ping ? S_DONE : S_GAP;
  // a zero gap still costs one idle cycle so the replay address restarts
  assign gap_load  = (gap_q == '0) ? '0 : gap_q - GAP_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    len_cnt_n = len_cnt;
    gap_cnt_n = gap_cnt;
    idx_n     = idx;
    latch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && bus.cfg_tx_len != '0) begin
          latch     = 1'b1;
          idx_n     = '0;
          len_cnt_n = bus.cfg_tx_len - LEN_W'(1);
          state_n   = PING_ENTRY;
        end
      end
      S_TX: begin
        if (len_cnt != '0) begin
          len_cnt_n = len_cnt - LEN_W'(1);
        end else if (rx_len_q != '0) begin
          len_cnt_n = rx_len_q - LEN_W'(1);
          state_n   = S_RX;
        end else begin
          gap_cnt_n = gap_load;
          state_n   = ping_end;
        end
      end
      S_RX: begin
        if (len_cnt != '0) begin
          len_cnt_n = len_cnt - LEN_W'(1);
        end else begin
          gap_cnt_n = gap_load;
          state_n   = ping_end;
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end else begin
          idx_n     = idx_inc;
          len_cnt_n = tx_len_q - LEN_W'(1);
          state_n   = PING_ENTRY;
        end
      end
      S_DONE: state_n = S_IDLE;
`ifdef SDU_PING_EXT_TRIG_EN
      // TX counter was already loaded on entry to ARM
      S_ARM: if (trig_edge) state_n = S_TX;
`endif
      default: state_n = S_IDLE;
    endcase

    // abort wins over everything, including a start in the same cycle
    if (bus.abort) begin
      state_n   = S_IDLE;
      latch     = 1'b0;
      idx_n     = idx;
      len_cnt_n = '0;
      gap_cnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_cnt               <= '0;
      gap_cnt               <= '0;
      idx                   <= '0;
      tx_len_q              <= '0;
      rx_len_q              <= '0;
      gap_q                 <= '0;
      num_q                 <= '0;
      bus.tx_en             <= 1'b0;
      bus.rx_en             <= 1'b0;
      bus.busy              <= 1'b0;
      bus.ping_start_strobe <= 1'b0;
      bus.seq_done_strobe   <= 1'b0;
    end else begin
      len_cnt <= len_cnt_n;
      gap_cnt <= gap_cnt_n;
      idx     <= idx_n;
      if (latch) begin
        tx_len_q <= bus.cfg_tx_len;
        rx_len_q <= bus.cfg_rx_len;
        gap_q    <= bus.cfg_gap;
        num_q    <= bus.cfg_num_pings;
      end
      bus.tx_en             <= (state_n == S_TX);
      bus.rx_en             <= (state_n == S_RX);
      bus.busy              <= (state_n != S_IDLE);
      bus.ping_start_strobe <= (state_n == S_TX) && (state != S_TX);
      bus.seq_done_strobe   <= (state_n == S_DONE);
    end
  end

  assign bus.ping_idx = idx;

endmodule

// File: doc/sdu_ping_ctrl.md
Name: sdu_ping_ctrl

Overview:
Ping sequencer directly upstream of the SDUltrasound TX replay stage. It generates the tx_en gate that makes the replay stage play its stored waveform from address 0. It then opens an RX listen window and waits an inter-ping gap, repeating for a programmed number of pings. It reports per-ping and end-of-sequence strobes to the PC-side control logic.

Parameters:
LEN_W, 16, width of cfg_tx_len / cfg_rx_len and their counters
GAP_W, 32, width of cfg_gap and gap counter
IDX_W, 16, width of cfg_num_pings and ping_idx

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
start  input  1  one-cycle request to begin a sequence
abort  input  1  one-cycle request to stop immediately
cfg_tx_len  input  LEN_W  TX burst length in cycles per ping
cfg_rx_len  input  LEN_W  RX listen window length in cycles (0 = none)
cfg_gap  input  GAP_W  idle cycles between pings (effective minimum 1)
cfg_num_pings  input  IDX_W  pings per sequence (0 = continuous until abort)
tx_en  output  1  gate to the TX replay stage
rx_en  output  1  RX capture window
busy  output  1  sequence in progress
ping_start_strobe  output  1  high in the first tx_en cycle of each ping
seq_done_strobe  output  1  one-cycle pulse on normal sequence completion
ping_idx  output  IDX_W  zero-based index of the current/last ping

Behaviour:
- Reset: state IDLE; tx_en, rx_en, busy, ping_start_strobe, seq_done_strobe = 0; ping_idx = 0; all counters 0.
- States: IDLE, TX, RX, GAP, DONE. Registered outputs. All timings count from start sampled high at cycle 0.
- IDLE:
  - start=1 with cfg_tx_len!=0: latch all cfg_* inputs, ping_idx<=0, go TX.
  - start with cfg_tx_len==0: ignored, remain IDLE.
- TX:
  - tx_en=1 for exactly L=cfg_tx_len cycles: cycles 1..L of ping 0.
  - busy=1 from cycle 1.
  - ping_start_strobe=1 only in the first TX cycle.
  - After L cycles, go to RX if R!=0. If R==0, go to GAP, or to DONE on the last ping.
- RX: rx_en=1 for exactly R=cfg_rx_len cycles. tx_en=0 throughout.
- Last-ping test: after the RX phase (or the TX phase if R==0), the current ping is last when cfg_num_pings!=0 and ping_idx+1==cfg_num_pings. The last ping skips GAP and goes to DONE.
- GAP:
  - tx_en=rx_en=0 for G'=max(cfg_gap,1) cycles. The minimum of 1 guarantees tx_en drops between pings so the replay address restarts at 0.
  - Then ping_idx<=ping_idx+1 and go TX.
  - Ping period = L+R+G' cycles.
- DONE: one cycle with seq_done_strobe=1 and busy=1, then IDLE with busy=0. ping_idx holds its last value.
- Continuous mode (cfg_num_pings==0): never enters DONE. ping_idx wraps modulo 2^IDX_W.
- Config inputs are ignored while busy; only the values latched at start are used.
- start while busy is ignored.
- abort (any non-IDLE state):
  - Next cycle is IDLE with tx_en=rx_en=busy=0.
  - No seq_done_strobe. ping_idx holds.
  - abort has priority over start in the same cycle.
- reset mid-sequence: immediate return to reset values on the next clock.
- Counters are down-counters loaded on phase entry. Full-width configuration values are legal (L=2^LEN_W-1, G=2^GAP_W-1).

Optional Feature:
SDU_PING_EXT_TRIG_EN
- Defined:
  - Adds input ext_trig (1 bit, asynchronous). It is passed through a 2-flop synchroniser, then rising-edge detected.
  - Adds state ARM before every TX phase, including the first: outputs low, busy=1, wait for a detected edge.
  - The edge detected in cycle n makes TX start in cycle n+1.
  - abort leaves ARM to IDLE.
  - GAP still runs before ARM.
- Undefined: no ext_trig port, no ARM state; timing exactly as above.

Test Plan:
- L=4,R=3,G=5,N=2, start at cycle 0:
  - tx_en cycles 1-4 and 13-16; rx_en cycles 5-7 and 17-19.
  - ping_start_strobe at cycles 1 and 13; ping_idx=1 from cycle 13.
  - seq_done_strobe at cycle 20; busy low from cycle 21.
- L=2,R=0,G=0,N=3: tx_en high cycles 1-2, 4-5, 7-8 (1-cycle gaps); seq_done_strobe at cycle 9.
- L=0, start -> busy stays 0, no strobes. L=3,N=1, start repeated at cycle 2 -> ignored; tx_en cycles 1-3 only.
- L=5,R=5,N=0, abort at cycle 30:
  - Before abort: continuous pings with period 11, ping_idx increments each ping.
  - From cycle 31: all outputs 0, no seq_done_strobe.
- L=4,R=2,G=3,N=2; reset at cycle 6 -> from cycle 7 all outputs and ping_idx 0. A new start then runs a clean sequence.
- With SDU_PING_EXT_TRIG_EN, L=2,R=1,G=1,N=2:
  - No tx_en until the first ext_trig edge.
  - tx_en starts 1 cycle after the synchronised edge detection.
  - The second ping waits for a second edge after its gap.
